sram_req_arbiter: RTL and testbench
===================================

// Module: sram_req_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the instruction-fetch requester and the
//  load/store requester of the 5-stage core (req/addr_ok/data_ok protocol). Selects one
//  request per cycle, tracks up to OUTSTANDING in-order transactions, and routes each
//  data_ok/rdata response back to the requester that issued it. Sits between the core's
//  inst/data ports and the single memory-side bridge.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width; CMD_W = 1+2+4+ADDR_W+DATA_W = {wr,size[1:0],wstrb[3:0],addr,wdata}
//  OUTSTANDING  4   max accepted-but-unanswered transactions (power of 2, >=2)
//  STARVE_LIMIT 4   consecutive data grants while inst_req is pending before inst is forced in
// PORTS
//  clk           in   1       clock, all state on rising edge
//  resetn        in   1       asynchronous active-low reset
//  inst_req      in   1       instruction-side request
//  inst_cmd      in   CMD_W   instruction-side command bundle
//  inst_addr_ok  out  1       instruction request accepted this cycle
//  inst_data_ok  out  1       instruction response valid this cycle
//  inst_rdata    out  DATA_W  instruction response data
//  data_req      in   1       load/store-side request
//  data_cmd      in   CMD_W   load/store-side command bundle
//  data_addr_ok  out  1       load/store request accepted this cycle
//  data_data_ok  out  1       load/store response valid this cycle
//  data_rdata    out  DATA_W  load/store response data
//  mem_req       out  1       shared-port request
//  mem_cmd       out  CMD_W   shared-port command (mux of winner)
//  mem_addr_ok   in   1       memory accepted mem_req this cycle
//  mem_data_ok   in   1       memory returns response (in issue order)
//  mem_rdata     in   DATA_W  memory response data
//  err_spurious  out  1       registered pulse: mem_data_ok seen with no outstanding transaction
//  busy          out  1       count!=0 | mem_req
// BEHAVIOUR
//  - Reset (async, resetn=0): count, rd/wr ptr, hold_vld, starve_cnt, err_spurious cleared;
//    mem_req, all *_addr_ok, all *_data_ok, busy = 0. Takes effect immediately, mid-transaction
//    entries are dropped; no response is routed after reset.
//  - Arbitration (combinational, zero-latency request path): if hold_vld, winner = hold_src.
//    Else data_req wins over inst_req, except when starve_cnt==STARVE_LIMIT and inst_req=1.
//  - mem_req = (inst_req|data_req) & !full; full = registered (count==OUTSTANDING). A pop in the
//    same cycle does NOT unblock (no mem_data_ok -> mem_req path).
//  - <src>_addr_ok = mem_req & mem_addr_ok & (winner==src); the loser always sees addr_ok=0.
//  - Hold: mem_req=1 & mem_addr_ok=0 -> hold_vld<=1, hold_src<=winner; cleared on the accepting
//    cycle. Requesters keep req/cmd stable until addr_ok (protocol rule); grant never switches
//    while held.
//  - Source FIFO (OUTSTANDING x 1 bit): push winner on mem_req&mem_addr_ok; pop on mem_data_ok
//    & count!=0. Push and pop in the same cycle: count unchanged, both pointers advance, wrap mod
//    OUTSTANDING.
//  - Response: <src>_data_ok = mem_data_ok & count!=0 & (head_src==src); both *_rdata = mem_rdata.
//  - mem_data_ok with count==0: ignored, no data_ok, err_spurious=1 the next cycle for 1 cycle.
//  - starve_cnt: +1 on each data grant while inst_req=1 (saturates at STARVE_LIMIT); cleared on
//    any inst grant or when inst_req=0.
// TESTING
//  1 reset; inst_req=data_req=1, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, count 0->1.
//  2 data_req alone, mem_addr_ok=0 x3 cycles, inst_req rises cycle 2 -> mem_cmd stays data_cmd;
//    on cycle 4 mem_addr_ok=1 -> data_addr_ok=1, hold_vld cleared.
//  3 4 inst reads accepted, no data_ok -> 5th cycle mem_req=0; data_ok x4 with rdata
//    0x11,0x22,0x33,0x44 -> inst_data_ok x4 with same data in order, count 0.
//  4 issue inst, data, inst; 3 mem_data_ok -> inst_data_ok, data_data_ok, inst_data_ok in order;
//    also push+pop same cycle leaves count unchanged.
//  5 both req held high, mem_addr_ok=1 every cycle -> grant sequence D,D,D,D,I,D,D,D,D,I.
//  6 mem_data_ok with count==0 -> err_spurious=1 next cycle only; resetn=0 with count=2 ->
//    outputs 0 immediately, later mem_data_ok raises err_spurious, no *_data_ok.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// ----------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM-like memory port (req / addr_ok / data_ok handshake) between
// the instruction-fetch requester and the load/store requester of the core.
// One request is granted per cycle. Up to OUTSTANDING accepted transactions are
// tracked in issue order, and each memory response is routed back to the
// requester that issued it.
//
// Arbitration is combinational, so a request reaches the memory port in the
// same cycle it is raised. Load/store normally wins. Instruction fetch is
// forced in after STARVE_LIMIT consecutive data grants while it was waiting.
// A request that the memory has not yet accepted keeps its grant until it is
// accepted.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req / inst_cmd         instruction-side request and command bundle
//   inst_addr_ok                instruction request accepted this cycle
//   inst_data_ok / inst_rdata   instruction response valid and its data
//   data_req / data_cmd         load/store-side request and command bundle
//   data_addr_ok                load/store request accepted this cycle
//   data_data_ok / data_rdata   load/store response valid and its data
//   mem_req / mem_cmd           shared memory-port request and muxed command
//   mem_addr_ok                 memory accepted mem_req this cycle
//   mem_data_ok / mem_rdata     in-order memory response and its data
//   err_spurious                one-cycle pulse, raised one cycle after a
//                               response arrives with nothing outstanding
//   busy                        transactions outstanding or a request pending
//
// Command bundle layout: {wr, size[1:0], wstrb[3:0], addr, wdata}
// ----------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int CMD_W       = 1 + 2 + 4 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [CMD_W-1:0]  inst_cmd,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [CMD_W-1:0]  data_cmd,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic [CMD_W-1:0]  mem_cmd,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_spurious,
    output logic              busy
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    // Tracking state
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    src_e             src_fifo [OUTSTANDING];
    logic             hold_vld;
    src_e             hold_src;
    logic [SC_W-1:0]  starve_cnt;
    logic             err_q;

    // Combinational decode
    src_e winner;
    logic full;
    logic starved;
    logic accept;
    logic has_entry;
    logic pop;
    src_e head_src;

    // full depends only on the registered count. A response arriving in the
    // same cycle therefore cannot re-open the request path, which keeps
    // mem_data_ok out of the mem_req timing path.
    assign full      = (count == CNT_W'(OUTSTANDING));
    assign starved   = inst_req && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign has_entry = (count != '0);
    assign pop       = mem_data_ok && has_entry;
    assign head_src  = src_fifo[rd_ptr];

    // NOTE: every variable driven in always_comb gets a default before any
    // branch. Without it, a path that skips the assignment infers a latch.
    always_comb begin
        winner = SRC_INST;
        if (hold_vld) begin
            winner = hold_src;
        end else if (data_req && !starved) begin
            winner = SRC_DATA;
        end
    end

    // Outputs are forced low by resetn so that they drop as soon as reset
    // asserts, including while requesters still drive their req lines high.
    assign mem_req      = resetn && (inst_req || data_req) && !full;
    assign mem_cmd      = (winner == SRC_DATA) ? data_cmd : inst_cmd;
    assign accept       = mem_req && mem_addr_ok;

    assign inst_addr_ok = accept && (winner == SRC_INST);
    assign data_addr_ok = accept && (winner == SRC_DATA);

    assign inst_data_ok = pop && (head_src == SRC_INST);
    assign data_data_ok = pop && (head_src == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign err_spurious = err_q;
    assign busy         = has_entry || mem_req;

    // NOTE: sequential state is written with non-blocking assignments only.
    // Every register then samples values from before the clock edge,
    // whatever order the statements appear in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            hold_vld   <= 1'b0;
            hold_src   <= SRC_INST;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            // Occupancy. A simultaneous push and pop cancel out, but both
            // pointers still advance.
            unique case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // OUTSTANDING is a power of two, so the pointers wrap naturally.
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);

            // Lock the grant while the memory is stalling the request, so the
            // command on mem_cmd cannot change under a pending handshake.
            if (mem_req && !mem_addr_ok) begin
                hold_vld <= 1'b1;
                hold_src <= winner;
            end else if (accept) begin
                hold_vld <= 1'b0;
            end

            // Count data grants that overtook a waiting instruction fetch.
            if (!inst_req || inst_addr_ok) begin
                starve_cnt <= '0;
            end else if (data_addr_ok && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end

            err_q <= mem_data_ok && !has_entry;
        end
    end

    // NOTE: the source FIFO storage is not reset. An entry is only read after
    // it has been written, because count gates every pop. Leaving it out of
    // reset lets it map onto plain flops or a small RAM.
    always_ff @(posedge clk) begin
        if (accept) src_fifo[wr_ptr] <= winner;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_req_arbiter
//
// Directed scenarios, followed by a protocol-abiding random phase, for
// sram_req_arbiter. Expected outputs come from a transaction-level reference
// model:
//   - a queue of issuing sources (0 = inst, 1 = data)
//   - the currently locked requester, if any
//   - a plain integer starvation counter
//   - a pending-error flag
// Inputs change 1 ns after the rising edge. Outputs are checked at the
// falling edge. The model advances at the rising edge.
// ----------------------------------------------------------------------------
module tb_sram_req_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OUTST  = 4;
    localparam int SLIM   = 4;
    localparam int CMD_W  = 1 + 2 + 4 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              resetn;
    logic              inst_req, data_req;
    logic [CMD_W-1:0]  inst_cmd, data_cmd;
    logic              inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [DATA_W-1:0] inst_rdata, data_rdata;
    logic              mem_req;
    logic [CMD_W-1:0]  mem_cmd;
    logic              mem_addr_ok, mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic              err_spurious, busy;

    sram_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTANDING(OUTST), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cmd(inst_cmd), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_cmd(data_cmd), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err_spurious(err_spurious), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit src_q[$];        // issuing source of each outstanding transaction
    int held      = -1;  // locked requester: -1 none, 0 inst, 1 data
    int starve    = 0;   // data grants while inst waited
    bit spur_exp  = 1'b0;
    bit last_iacc = 1'b0;
    bit last_dacc = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] rand_cmd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[CMD_W-1:0];
    endfunction

    task automatic model_reset();
        src_q.delete();
        held     = -1;
        starve   = 0;
        spur_exp = 1'b0;
    endtask

    // One clock cycle with the inputs currently driven.
    // Entry and exit are 1 ns after a rising edge.
    task automatic cycle(input string tag);
        int w;
        int sz;
        bit mreq_e, acc, pop, head;
        #4;
        sz     = src_q.size();
        mreq_e = (inst_req || data_req) && (sz != OUTST);
        if (held >= 0)                                    w = held;
        else if (data_req && !(starve >= SLIM && inst_req)) w = 1;
        else                                              w = 0;
        acc  = mreq_e && mem_addr_ok;
        pop  = mem_data_ok && (sz != 0);
        head = pop ? src_q[0] : 1'b0;

        chk({tag, ".mem_req"},      mem_req,      mreq_e);
        chk({tag, ".inst_addr_ok"}, inst_addr_ok, acc && (w == 0));
        chk({tag, ".data_addr_ok"}, data_addr_ok, acc && (w == 1));
        if (mreq_e) chk({tag, ".mem_cmd"}, mem_cmd, (w == 1) ? data_cmd : inst_cmd);
        chk({tag, ".inst_data_ok"}, inst_data_ok, pop && !head);
        chk({tag, ".data_data_ok"}, data_data_ok, pop && head);
        chk({tag, ".inst_rdata"},   inst_rdata,   mem_rdata);
        chk({tag, ".data_rdata"},   data_rdata,   mem_rdata);
        chk({tag, ".err_spurious"}, err_spurious, spur_exp);
        chk({tag, ".busy"},         busy,         (sz != 0) || mreq_e);

        @(posedge clk);
        if (pop) void'(src_q.pop_front());
        if (acc) src_q.push_back(w[0]);
        if (mreq_e && !mem_addr_ok) held = w;
        else if (acc)               held = -1;
        if (!inst_req || (acc && w == 0))             starve = 0;
        else if (acc && w == 1 && starve < SLIM)      starve++;
        spur_exp  = mem_data_ok && (sz == 0);
        last_iacc = acc && (w == 0);
        last_dacc = acc && (w == 1);
        #1;
    endtask

    task automatic drive(input bit ir, input bit dr, input bit aok, input bit dok);
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = $urandom();
    endtask

    task automatic check_all_low(input string tag);
        chk({tag, ".mem_req"},      mem_req,      1'b0);
        chk({tag, ".inst_addr_ok"}, inst_addr_ok, 1'b0);
        chk({tag, ".data_addr_ok"}, data_addr_ok, 1'b0);
        chk({tag, ".inst_data_ok"}, inst_data_ok, 1'b0);
        chk({tag, ".data_data_ok"}, data_data_ok, 1'b0);
        chk({tag, ".err_spurious"}, err_spurious, 1'b0);
        chk({tag, ".busy"},         busy,         1'b0);
    endtask

    string grant_exp = "DDDDIDDDDI";

    initial begin
        // ---------------- reset ----------------
        resetn   = 1'b0;
        inst_cmd = rand_cmd();
        data_cmd = rand_cmd();
        drive(1, 1, 1, 1);
        #12;
        check_all_low("reset");
        drive(0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // ---- 1: simultaneous requests, data wins ----
        drive(1, 1, 1, 0);
        cycle("t1.both");
        chk("t1.busy_after", busy, 1'b1);
        drive(1, 0, 1, 0);
        cycle("t1.inst");
        drive(0, 0, 0, 1);
        cycle("t1.resp0");
        cycle("t1.resp1");

        // ---- 2: grant held while memory stalls ----
        data_cmd = rand_cmd();
        inst_cmd = rand_cmd();
        drive(0, 1, 0, 0);
        cycle("t2.c1");
        drive(1, 1, 0, 0);
        cycle("t2.c2");
        cycle("t2.c3");
        chk("t2.held_cmd", mem_cmd, data_cmd);
        drive(1, 1, 1, 0);
        cycle("t2.c4");
        drive(1, 0, 1, 0);
        cycle("t2.c5");
        drive(0, 0, 0, 1);
        cycle("t2.r0");
        cycle("t2.r1");

        // ---- 3: fill to OUTSTANDING, then in-order responses ----
        for (int i = 0; i < OUTST + 1; i++) begin
            inst_cmd = rand_cmd();
            drive(1, 0, 1, 0);
            cycle($sformatf("t3.issue%0d", i));
        end
        for (int i = 0; i < OUTST; i++) begin
            drive(0, 0, 0, 1);
            mem_rdata = 32'h11 * (i + 1);
            cycle($sformatf("t3.resp%0d", i));
        end
        drive(0, 0, 0, 0);
        cycle("t3.idle");

        // ---- 4: mixed sources, push and pop in the same cycle ----
        inst_cmd = rand_cmd();
        drive(1, 0, 1, 0);
        cycle("t4.i0");
        data_cmd = rand_cmd();
        drive(0, 1, 1, 0);
        cycle("t4.d0");
        inst_cmd = rand_cmd();
        drive(1, 0, 1, 1);
        cycle("t4.i1_pop");
        chk("t4.busy_mid", busy, 1'b1);
        drive(0, 0, 0, 1);
        cycle("t4.pop_d");
        cycle("t4.pop_i");
        drive(0, 0, 0, 0);
        cycle("t4.idle");

        // ---- 5: sustained contention, starvation breaker ----
        for (int i = 0; i < 10; i++) begin
            bit dok;
            bit got_data;
            inst_cmd = rand_cmd();
            data_cmd = rand_cmd();
            dok = (i != 0);
            drive(1, 1, 1, dok);
            cycle($sformatf("t5.g%0d", i));
            got_data = (grant_exp[i] == "D");
            chk($sformatf("t5.seq%0d", i), last_dacc, got_data);
        end
        drive(0, 0, 0, 1);
        cycle("t5.drain");
        drive(0, 0, 0, 0);
        cycle("t5.idle");

        // ---- 6: spurious response, then reset with transactions in flight ----
        drive(0, 0, 0, 1);
        cycle("t6.spur");
        drive(0, 0, 0, 0);
        cycle("t6.err_hi");
        cycle("t6.err_lo");
        inst_cmd = rand_cmd();
        drive(1, 0, 1, 0);
        cycle("t6.i");
        data_cmd = rand_cmd();
        drive(0, 1, 1, 0);
        cycle("t6.d");
        drive(1, 1, 1, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_low("t6.rst");
        model_reset();
        @(posedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1);
        cycle("t6.post_rst");
        drive(0, 0, 0, 0);
        cycle("t6.post_err");
        cycle("t6.post_idle");

        // ---- random phase: requesters keep req/cmd until accepted ----
        inst_req = 1'b0;
        data_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!inst_req || last_iacc) begin
                inst_req = ($urandom_range(0, 2) != 0);
                inst_cmd = rand_cmd();
            end
            if (!data_req || last_dacc) begin
                data_req = ($urandom_range(0, 2) != 0);
                data_cmd = rand_cmd();
            end
            mem_addr_ok = ($urandom_range(0, 9) < 7);
            mem_data_ok = ($urandom_range(0, 9) < 4);
            mem_rdata   = $urandom();
            cycle($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
